// File: rtl/fir_pkg.sv
// Shared state type, default sizes and counter-width helper for the FIR
// coefficient controller.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SWAP  = 2'd1,
        ST_FLUSH = 2'd2
    } fir_state_e;

    localparam int FIR_NTAPS = 4;
    localparam int FIR_DW    = 8;
    localparam int FIR_CW    = 8;

    function automatic int fir_cnt_width(input int ntaps);
        return $clog2(ntaps + 1);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient register banks; the active bank is loaded from
// the shadow bank in a single edge on i_swap and drives the filter taps.
module fir_coef_bank #(
    parameter int NTAPS = 4,
    parameter int CW    = 8,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [CW-1:0]       i_wr_data,
    input  logic                i_swap,
    output logic [NTAPS*CW-1:0] o_coef_flat
);

    logic [CW-1:0] r_shadow [NTAPS];
    logic [CW-1:0] r_active [NTAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_shadow[i_wr_addr] <= i_wr_data;
            end
            if (i_swap) begin
                for (int i = 0; i < NTAPS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    for (genvar i = 0; i < NTAPS; i++) begin : g_flat
        assign o_coef_flat[i*CW +: CW] = r_active[i];
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Sample handshake and atomic shadow->active coefficient swap in front of fir_filter.
// Define FIR_CTRL_FLUSH_EN to push NTAPS zero samples into the filter after every swap.
//
// state    | meaning
// ST_RUN   | samples, shadow writes and commit accepted
// ST_SWAP  | active bank loaded from shadow on this edge
// ST_FLUSH | zero samples strobed into the filter for NTAPS cycles
module fir_coef_ctrl
    import fir_pkg::*;
#(
    parameter int NTAPS = FIR_NTAPS,
    parameter int DW    = FIR_DW,
    parameter int CW    = FIR_CW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(NTAPS)-1:0] wr_addr,
    input  logic [CW-1:0]            wr_data,
    input  logic                     commit,
    input  logic                     s_valid,
    input  logic [DW-1:0]            s_data,
    output logic                     s_ready,
    output logic [DW-1:0]            fir_x,
    output logic                     fir_en,
    output logic [NTAPS*CW-1:0]      coef_flat,
    output logic                     busy,
    output logic                     commit_done,
    output logic                     cmd_err
);

    fir_state_e    r_state;
    fir_state_e    w_state_nxt;
    logic          w_bank_we;
    logic          w_swap;
    logic          w_drop;
    logic [DW-1:0] r_fir_x;
    logic          r_fir_en;
    logic          r_commit_done;
    logic          r_cmd_err;

`ifdef FIR_CTRL_FLUSH_EN
    localparam int CNTW = fir_cnt_width(NTAPS);
    logic [CNTW-1:0] r_flush_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bank_we   = 1'b0;
        w_swap      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_bank_we = wr_en;
                if (commit) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_swap = 1'b1;
                w_drop = wr_en | commit;
`ifdef FIR_CTRL_FLUSH_EN
                w_state_nxt = ST_FLUSH;
`else
                w_state_nxt = ST_RUN;
`endif
            end
`ifdef FIR_CTRL_FLUSH_EN
            ST_FLUSH: begin
                w_drop = wr_en | commit;
                if (r_flush_cnt == CNTW'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign s_ready = (r_state == ST_RUN);
    assign busy    = (r_state != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fir_x       <= '0;
            r_fir_en      <= 1'b0;
            r_commit_done <= 1'b0;
            r_cmd_err     <= 1'b0;
`ifdef FIR_CTRL_FLUSH_EN
            r_flush_cnt   <= '0;
`endif
        end else begin
            r_fir_en      <= 1'b0;
            r_commit_done <= 1'b0;
            r_cmd_err     <= w_drop;
            case (r_state)
                ST_RUN: begin
                    if (s_valid) begin
                        r_fir_x  <= s_data;
                        r_fir_en <= 1'b1;
                    end
                end
                ST_SWAP: begin
`ifdef FIR_CTRL_FLUSH_EN
                    r_flush_cnt   <= CNTW'(NTAPS);
`else
                    r_commit_done <= 1'b1;
`endif
                end
`ifdef FIR_CTRL_FLUSH_EN
                ST_FLUSH: begin
                    r_fir_x     <= '0;
                    r_fir_en    <= 1'b1;
                    r_flush_cnt <= r_flush_cnt - CNTW'(1);
                    // done pulse lands with the last zero strobe
                    if (r_flush_cnt == CNTW'(1)) begin
                        r_commit_done <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .AW    ($clog2(NTAPS))
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_bank_we),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_swap      (w_swap),
        .o_coef_flat (coef_flat)
    );

    assign fir_x       = r_fir_x;
    assign fir_en      = r_fir_en;
    assign commit_done = r_commit_done;
    assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed plus randomized bench for fir_coef_ctrl against a cycle-timeline model;
// follows FIR_CTRL_FLUSH_EN to pick the flush length.
module tb_fir_coef_ctrl;

    localparam int NTAPS = 4;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int AW    = $clog2(NTAPS);
`ifdef FIR_CTRL_FLUSH_EN
    localparam int FL = NTAPS;
`else
    localparam int FL = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [CW-1:0]       wr_data;
    logic                commit;
    logic                s_valid;
    logic [DW-1:0]       s_data;
    logic                s_ready;
    logic [DW-1:0]       fir_x;
    logic                fir_en;
    logic [NTAPS*CW-1:0] coef_flat;
    logic                busy;
    logic                commit_done;
    logic                cmd_err;

    always #5 clk = ~clk;

    fir_coef_ctrl #(.NTAPS(NTAPS), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .fir_x       (fir_x),
        .fir_en      (fir_en),
        .coef_flat   (coef_flat),
        .busy        (busy),
        .commit_done (commit_done),
        .cmd_err     (cmd_err)
    );

    int total = 0;
    int bad   = 0;

    // Model: a commit starts a timeline; age 1 swaps, ages 2..FL+1 flush, FL+1 ends it.
    logic [CW-1:0] m_shadow [NTAPS];
    logic [CW-1:0] m_active [NTAPS];
    logic          m_busy;
    int            m_age;
    logic [DW-1:0] e_x;
    logic          e_en, e_done, e_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NTAPS*CW-1:0] exp_flat();
        logic [NTAPS*CW-1:0] f;
        for (int i = 0; i < NTAPS; i++) f[i*CW +: CW] = m_active[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_busy = 1'b0;
        m_age  = 0;
        e_x    = '0;
        e_en   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [AW-1:0] a, input logic [CW-1:0] d,
                              input logic cm, input logic v, input logic [DW-1:0] sd);
        e_en   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!m_busy) begin
            if (we) m_shadow[a] = d;
            if (v) begin
                e_x  = sd;
                e_en = 1'b1;
            end
            if (cm) begin
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else begin
            m_age++;
            if (we || cm) e_err = 1'b1;
            if (m_age == 1) begin
                for (int i = 0; i < NTAPS; i++) m_active[i] = m_shadow[i];
            end else begin
                e_x  = '0;
                e_en = 1'b1;
            end
            if (m_age == FL + 1) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("fir_x",       64'(fir_x),       64'(e_x));
        chk("fir_en",      64'(fir_en),      64'(e_en));
        chk("s_ready",     64'(s_ready),     64'(!m_busy));
        chk("busy",        64'(busy),        64'(m_busy));
        chk("commit_done", 64'(commit_done), 64'(e_done));
        chk("cmd_err",     64'(cmd_err),     64'(e_err));
        chk("coef_flat",   64'(coef_flat),   64'(exp_flat()));
    endtask

    task automatic step(input logic we, input logic [AW-1:0] a, input logic [CW-1:0] d,
                        input logic cm, input logic v, input logic [DW-1:0] sd);
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        commit  = cm;
        s_valid = v;
        s_data  = sd;
        @(posedge clk);
        model_edge(we, a, d, cm, v, sd);
        #1;
        check_all();
        wr_en   = 1'b0;
        commit  = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int n_busy, n_en, n_done, guard;
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; s_valid = 1'b0; s_data = '0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // sample path
        for (int k = 1; k <= 4; k++) step(1'b0, '0, '0, 1'b0, 1'b1, DW'(k));

        // load taps 1..4 and commit
        for (int k = 0; k < NTAPS; k++) step(1'b1, AW'(k), CW'(k + 1), 1'b0, 1'b0, '0);
        n_busy = 0; n_en = 0; n_done = 0;
        for (int k = 0; k <= FL + 2; k++) begin
            if (k == 0) step(1'b0, '0, '0, 1'b1, 1'b0, '0);
            else idle();
            if (k == 1) chk("coef_after_swap", 64'(coef_flat), 64'h04030201);
            n_busy += int'(busy);
            n_en   += int'(fir_en);
            n_done += int'(commit_done);
        end
        chk("busy_cycles",   64'(n_busy), 64'(FL + 1));
        chk("flush_strobes", 64'(n_en),   64'(FL));
        chk("done_pulses",   64'(n_done), 64'(1));

        // write and commit in the same cycle
        step(1'b1, AW'(2), 8'h7F, 1'b1, 1'b0, '0);
        for (int k = 0; k < FL + 2; k++) idle();
        chk("tap2_7f", 64'(coef_flat[2*CW +: CW]), 64'h7F);

        // requests while busy are dropped
        step(1'b0, '0, '0, 1'b1, 1'b0, '0);
        if (FL > 0) idle();
        guard = 0;
        while (m_busy && guard < 20) begin
            step(1'b1, AW'(guard), 8'hA5, guard[0], 1'b1, 8'h33);
            guard++;
        end
        idle();
        step(1'b0, '0, '0, 1'b1, 1'b0, '0);
        for (int k = 0; k < FL + 2; k++) idle();
        chk("shadow_kept_tap0", 64'(coef_flat[0 +: CW]), 64'h01);

        // reset in the middle of a swap/flush
        step(1'b1, AW'(1), 8'h5A, 1'b1, 1'b0, '0);
        for (int k = 0; k < (FL > 0 ? 2 : 0); k++) idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("coef_zero_rst", 64'(coef_flat), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h9C);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h01);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 4) == 0, AW'($urandom), CW'($urandom),
                 ($urandom % 16) == 0, ($urandom % 2) == 1, DW'($urandom));
        end
        for (int k = 0; k < FL + 2; k++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
